// File: rtl/pipelined_multi_sum_plus_const_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_multi_sum_plus_const_if
//  Brief    : Valid/ready operand and result bus for the multi-term adder.
//  Revision : 1.0  initial release
// ============================================================================
interface pipelined_multi_sum_plus_const_if #(
    parameter int SIZE   = 12,
    parameter int NUM_IN = 4
);
    localparam int OUT_W = SIZE + $clog2(NUM_IN + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_IN*SIZE-1:0] in_data;
    logic [NUM_IN-1:0]      sub_mask;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_sum;

    modport master (
        output in_valid, in_data, sub_mask, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_data, sub_mask, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_multi_sum_plus_const.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_multi_sum_plus_const
//  Brief    : 3-stage carry-save signed sum of +/- operands plus a constant.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_multi_sum_plus_const #(
    parameter int        SIZE   = 12,
    parameter int        NUM_IN = 4,
    parameter int signed CONST  = 1
) (
    input  wire logic clk,
    input  wire logic sclr,
    pipelined_multi_sum_plus_const_if.slave bus
);
    localparam int OUT_W   = SIZE + $clog2(NUM_IN + 1);
    localparam int C_EXT_W = OUT_W - SIZE;

    function automatic logic [OUT_W-1:0] sext(input logic [SIZE-1:0] v);
        return {{C_EXT_W{v[SIZE-1]}}, v};
    endfunction

    logic [SIZE-1:0]  r_s1_op_q   [NUM_IN];
    logic [SIZE-1:0]  w_s1_op_d   [NUM_IN];
    logic [OUT_W-1:0] r_s1_corr_q,  w_s1_corr_d;
    logic             r_s1_valid_q, w_s1_valid_d;
    logic [OUT_W-1:0] r_s2_sum_q,   w_s2_sum_d;
    logic [OUT_W-1:0] r_s2_carry_q, w_s2_carry_d;
    logic             r_s2_valid_q, w_s2_valid_d;
    logic [OUT_W-1:0] r_out_sum_q,  w_out_sum_d;
    logic             r_s3_valid_q, w_s3_valid_d;

    logic             w_s1_en, w_s2_en, w_s3_en;
    logic [OUT_W-1:0] w_csa_s, w_csa_c, w_csa_a, w_csa_t;

    // Each stage may load when its successor is empty or emptying this cycle.
    assign w_s3_en = ~r_s3_valid_q | bus.out_ready;
    assign w_s2_en = ~r_s2_valid_q | w_s3_en;
    assign w_s1_en = ~r_s1_valid_q | w_s2_en;

    assign bus.in_ready  = w_s1_en;
    assign bus.out_valid = r_s3_valid_q;
    assign bus.out_sum   = r_out_sum_q;

    // Subtraction is ~op + 1; the +1 terms fold into the correction word with CONST.
    always_comb begin
        w_s1_valid_d = r_s1_valid_q;
        w_s1_corr_d  = r_s1_corr_q;
        for (int i = 0; i < NUM_IN; i++) begin
            w_s1_op_d[i] = r_s1_op_q[i];
        end
        if (w_s1_en) begin
            w_s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                w_s1_corr_d = OUT_W'(CONST);
                for (int i = 0; i < NUM_IN; i++) begin
                    w_s1_op_d[i] = bus.in_data[i*SIZE +: SIZE] ^ {SIZE{bus.sub_mask[i]}};
                    w_s1_corr_d  = w_s1_corr_d + OUT_W'(bus.sub_mask[i]);
                end
            end
        end
    end

    // Linear chain of 3:2 compressors over the operands and the correction word.
    always_comb begin
        w_csa_s = sext(r_s1_op_q[0]);
        w_csa_c = sext(r_s1_op_q[1]);
        w_csa_a = '0;
        w_csa_t = '0;
        for (int k = 2; k <= NUM_IN; k++) begin
            w_csa_a = (k == NUM_IN) ? r_s1_corr_q : sext(r_s1_op_q[k % NUM_IN]);
            w_csa_t = w_csa_s ^ w_csa_c ^ w_csa_a;
            w_csa_c = ((w_csa_s & w_csa_c) | (w_csa_s & w_csa_a) | (w_csa_c & w_csa_a)) << 1;
            w_csa_s = w_csa_t;
        end
    end

    always_comb begin
        w_s2_valid_d = r_s2_valid_q;
        w_s2_sum_d   = r_s2_sum_q;
        w_s2_carry_d = r_s2_carry_q;
        if (w_s2_en) begin
            w_s2_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_s2_sum_d   = w_csa_s;
                w_s2_carry_d = w_csa_c;
            end
        end
    end

    always_comb begin
        w_s3_valid_d = r_s3_valid_q;
        w_out_sum_d  = r_out_sum_q;
        if (w_s3_en) begin
            w_s3_valid_d = r_s2_valid_q;
            if (r_s2_valid_q) begin
                w_out_sum_d = r_s2_sum_q + r_s2_carry_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_s1_valid_q <= 1'b0;
            r_s2_valid_q <= 1'b0;
            r_s3_valid_q <= 1'b0;
            r_s1_corr_q  <= '0;
            r_s2_sum_q   <= '0;
            r_s2_carry_q <= '0;
            r_out_sum_q  <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_s1_op_q[i] <= '0;
            end
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_s3_valid_q <= w_s3_valid_d;
            r_s1_corr_q  <= w_s1_corr_d;
            r_s2_sum_q   <= w_s2_sum_d;
            r_s2_carry_q <= w_s2_carry_d;
            r_out_sum_q  <= w_out_sum_d;
            for (int i = 0; i < NUM_IN; i++) begin
                r_s1_op_q[i] <= w_s1_op_d[i];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipelined_multi_sum_plus_const.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_multi_sum_plus_const
//  Brief    : Scoreboard bench for the pipelined multi-term adder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_multi_sum_plus_const;
    localparam int SIZE   = 12;
    localparam int NUM_IN = 4;
    localparam int CONST  = 1;
    localparam int OUT_W  = 15;

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    pipelined_multi_sum_plus_const_if #(.SIZE(SIZE), .NUM_IN(NUM_IN)) bus ();

    pipelined_multi_sum_plus_const #(.SIZE(SIZE), .NUM_IN(NUM_IN), .CONST(CONST)) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus)
    );

    logic signed [OUT_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [NUM_IN*SIZE-1:0] pack(input int o0, input int o1,
                                                     input int o2, input int o3);
        return {SIZE'(o3), SIZE'(o2), SIZE'(o1), SIZE'(o0)};
    endfunction

    // Monitor: compares every output transfer and checks stability while stalled.
    logic                    stalled = 1'b0;
    logic signed [OUT_W-1:0] held    = '0;
    always @(negedge clk) begin
        if (sclr) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_hold", int'(bus.out_valid), 1);
                check("stall_sum_hold", int'($signed(bus.out_sum)), int'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", int'($signed(bus.out_sum)), 99999);
                else check("result", int'($signed(bus.out_sum)), int'(exp_q.pop_front()));
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                held    = $signed(bus.out_sum);
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive(input logic [NUM_IN*SIZE-1:0] data, input logic [NUM_IN-1:0] mask,
                         input int expv, output int waits);
        bit done = 0;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.sub_mask = mask;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(OUT_W'(expv));
                done = 1;
            end else if (waits >= 50) begin
                check("in_ready_timeout", 0, 1);
                done = 1;
            end
            tick();
            if (!done) begin
                waits++;
                bus.out_ready = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = NUM_IN*SIZE'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    int w;
    int ops [NUM_IN];
    logic [NUM_IN-1:0] m;
    int ev;

    initial begin
        sclr = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sub_mask  = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);
        check("reset_out_sum", int'(bus.out_sum), 0);
        tick();
        sclr = 1'b0;

        // Latency: result appears exactly three edges after acceptance.
        drive(pack(2047, 2047, 2047, 2047), 4'b0000, 8189, w);
        @(negedge clk); check("latency_c1", int'(bus.out_valid), 0);
        @(negedge clk); check("latency_c2", int'(bus.out_valid), 0);
        @(negedge clk); check("latency_c3", int'(bus.out_valid), 1);
        tick();
        drain();

        // Back-to-back distinct sets with hand-computed sums.
        drive(pack(-2048, -2048, -2048, -2048), 4'b1111, 8193, w);
        check("b2b_no_wait0", w, 0);
        drive(pack(-2048, -2048, -2048, -2048), 4'b0000, -8191, w);
        check("b2b_no_wait1", w, 0);
        drive(pack(5, 7, 100, -3), 4'b0101, -100, w);
        drive(pack(0, 0, 0, 0), 4'b1111, 1, w);
        drive(pack(1, 2, 3, 4), 4'b1010, -1, w);
        drive(pack(-1, -1, -1, -1), 4'b0000, -3, w);
        drive(pack(2047, -2048, 2047, -2048), 4'b1010, 8191, w);
        drive(pack(100, 200, 300, 400), 4'b0001, 801, w);
        drain();

        // Junk data with in_valid low must not produce output.
        repeat (5) begin
            bus.in_data = NUM_IN*SIZE'($urandom);
            tick();
        end

        // Stall with three sets in flight.
        bus.out_ready = 1'b0;
        drive(pack(10, 20, 30, 40), 4'b0000, 101, w);
        drive(pack(10, 20, 30, 40), 4'b1111, -99, w);
        drive(pack(-7, 3, 0, 9), 4'b0100, 6, w);
        @(negedge clk);
        check("full_in_ready_low", int'(bus.in_ready), 0);
        repeat (6) tick();
        @(negedge clk);
        check("stalled_in_ready_low", int'(bus.in_ready), 0);
        tick();
        bus.out_ready = 1'b1;
        drive(pack(1, 1, 1, 1), 4'b0011, 1, w);
        check("full_flow_no_bubble", w, 0);
        drain();

        // Synchronous reset discards in-flight sets and a set offered during reset.
        drive(pack(500, 500, 500, 500), 4'b0000, 2001, w);
        drive(pack(600, 600, 600, 600), 4'b0000, 2401, w);
        sclr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = pack(9, 9, 9, 9);
        @(negedge clk);
        exp_q.delete();
        tick();
        sclr = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sclr_out_valid", int'(bus.out_valid), 0);
        check("sclr_in_ready", int'(bus.in_ready), 1);
        repeat (8) tick();

        // Random traffic against a reference sum.
        for (int it = 0; it < 400; it++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                ev = CONST;
                m  = NUM_IN'($urandom);
                for (int i = 0; i < NUM_IN; i++) begin
                    ops[i] = int'($urandom_range(0, 4095)) - 2048;
                    ev = m[i] ? ev - ops[i] : ev + ops[i];
                end
                drive(pack(ops[0], ops[1], ops[2], ops[3]), m, ev, w);
            end else begin
                tick();
            end
        end
        bus.out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
